// File: rtl/irq_debounce.sv
// Eight-channel button/switch debouncer with per-channel masked interrupt pulses.
// Each raw line is synchronized, debounced by a stable-sample count, and a rising
// acceptance fires a fixed-width pulse toward the CPU interrupt inputs.
module irq_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PULSE_WIDTH     = 1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] btn_in,
  input  logic [7:0] irq_mask,
  output logic [7:0] irq_out,
  output logic [7:0] level,
  output logic       irq_any
);

  localparam int unsigned NCH   = 8;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PW_W  = $clog2(PULSE_WIDTH + 1);

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW_W-1:0]  PW_LOAD = PW_W'(PULSE_WIDTH);

  logic [NCH-1:0]            s1_q,  s1_d;
  logic [NCH-1:0]            s2_q,  s2_d;
  logic [NCH-1:0]            lvl_q, lvl_d;
  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][PW_W-1:0]  pls_q, pls_d;
  logic [NCH-1:0]            irq_q, irq_d;
  logic                      any_q, any_d;
  logic [NCH-1:0]            rise_c;

  // Synchronizer and debounce: level flips only after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    s1_d   = btn_in;
    s2_d   = s1_q;
    lvl_d  = lvl_q;
    cnt_d  = cnt_q;
    rise_c = '0;
    for (int i = 0; i < NCH; i++) begin
      if (s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_MAX) begin
        lvl_d[i]  = s2_q[i];
        cnt_d[i]  = '0;
        rise_c[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Pulse generation: mask is sampled only at acceptance, so it never truncates a pulse.
  always_comb begin
    pls_d = pls_q;
    irq_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rise_c[i] && irq_mask[i]) begin
        pls_d[i] = PW_LOAD;
      end else if (pls_q[i] != '0) begin
        pls_d[i] = pls_q[i] - PW_W'(1);
      end
      irq_d[i] = (pls_d[i] != '0);
    end
    any_d = |irq_d;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      cnt_q <= '0;
      pls_q <= '0;
      irq_q <= '0;
      any_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      pls_q <= pls_d;
      irq_q <= irq_d;
      any_q <= any_d;
    end
  end

  assign irq_out = irq_q;
  assign level   = lvl_q;
  assign irq_any = any_q;

endmodule

// File: tb/tb_irq_debounce.sv
// Randomized and directed bench for irq_debounce, checked each cycle against an
// edge-counting reference model plus literal expectations for the key scenarios.
module tb_irq_debounce;

  localparam int DB = 4;
  localparam int PW = 2;

  logic       clk;
  logic       clr_n;
  logic [7:0] btn_in;
  logic [7:0] irq_mask;
  logic [7:0] irq_out;
  logic [7:0] level;
  logic       irq_any;

  int errors;
  int checks;

  irq_debounce #(.DEBOUNCE_CYCLES(DB), .PULSE_WIDTH(PW)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .btn_in   (btn_in),
    .irq_mask (irq_mask),
    .irq_out  (irq_out),
    .level    (level),
    .irq_any  (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sample history, run length of disagreeing samples, time of last pulse.
  logic [7:0] m_s1, m_s2, m_lvl, m_irq;
  int         m_run  [8];
  int         m_last [8];
  int         cyc;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_irq = '0;
    for (int i = 0; i < 8; i++) begin
      m_run[i]  = 0;
      m_last[i] = -1000;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 8; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DB) begin
          if (m_s2[i] && irq_mask[i]) m_last[i] = cyc;
          m_lvl[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_irq[i] = ((cyc - m_last[i]) < PW);
    end
    m_s2 = m_s1;
    m_s1 = btn_in;
    cyc  = cyc + 1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %02h expected %02h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model, then compare all outputs away from the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_level", level, m_lvl);
    chk("model_irq", irq_out, m_irq);
    chk("model_any", {7'b0, irq_any}, {7'b0, |m_irq});
  endtask

  // Short asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #1 clr_n = 1'b0;
    #1;
    model_reset();
    chk("rst_level", level, 8'h00);
    chk("rst_irq", irq_out, 8'h00);
    chk("rst_any", {7'b0, irq_any}, 8'h00);
    #2 clr_n = 1'b1;
  endtask

  int pulses;

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    clr_n    = 1'b1;
    btn_in   = '0;
    irq_mask = 8'hFF;
    model_reset();
    @(posedge clk);
    do_reset();
    step();
    step();

    // Single rising channel: pulse after E5, irq_any tracks it.
    btn_in = 8'h01;
    for (int e = 0; e <= 7; e++) begin
      step();
      if (e == 4) chk("r29_level_e4", level, 8'h00);
      if (e == 5) begin
        chk("r29_level_e5", level, 8'h01);
        chk("r29_irq_e5", irq_out, 8'h01);
        chk("r29_any_e5", {7'b0, irq_any}, 8'h01);
      end
      if (e == 6) chk("r29_any_e6", {7'b0, irq_any}, 8'h01);
      if (e == 7) begin
        chk("r29_irq_e7", irq_out, 8'h00);
        chk("r29_any_e7", {7'b0, irq_any}, 8'h00);
      end
    end

    // Too-short hold is rejected; a hold of DEBOUNCE_CYCLES gives one pulse.
    @(posedge clk);
    do_reset();
    btn_in = 8'h08;
    for (int e = 0; e < 3; e++) step();
    btn_in = 8'h00;
    for (int e = 0; e < 10; e++) begin
      step();
      chk("r30_short_lvl", level, 8'h00);
      chk("r30_short_irq", irq_out, 8'h00);
    end
    btn_in = 8'h08;
    pulses = 0;
    for (int e = 0; e < 4; e++) begin
      step();
      pulses += int'(irq_out[3]);
    end
    btn_in = 8'h00;
    for (int e = 0; e < 12; e++) begin
      step();
      pulses += int'(irq_out[3]);
    end
    chk("r30_pulse_len", 8'(pulses), 8'd2);

    // Masked rise: level only, no deferred pulse, no pulse on fall.
    @(posedge clk);
    do_reset();
    irq_mask = 8'hFE;
    btn_in   = 8'h01;
    for (int e = 0; e <= 5; e++) begin
      step();
      chk("r31_irq_masked", irq_out, 8'h00);
    end
    chk("r31_level_e5", level, 8'h01);
    irq_mask = 8'hFF;
    for (int e = 0; e < 4; e++) begin
      step();
      chk("r31_irq_unmask", irq_out, 8'h00);
    end
    btn_in = 8'h00;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk("r31_irq_fall", irq_out, 8'h00);
      if (e == 5) chk("r31_level_e5f", level, 8'h01);
      if (e == 6) chk("r31_level_e6f", level, 8'h00);
    end

    // Several channels at once pulse together.
    @(posedge clk);
    do_reset();
    btn_in = 8'hA5;
    for (int e = 0; e <= 8; e++) begin
      step();
      if (e == 5 || e == 6) chk("r32_irq_on", irq_out, 8'hA5);
      if (e == 7 || e == 8) chk("r32_irq_off", irq_out, 8'h00);
      if (e >= 5) chk("r32_level", level, 8'hA5);
    end

    // Async reset during a pulse, input still held high.
    @(posedge clk);
    do_reset();
    btn_in = 8'h01;
    for (int e = 0; e <= 5; e++) step();
    chk("r33_irq_pre", irq_out, 8'h01);
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e < 6) chk("r33_irq_wait", irq_out, 8'h00);
      else       chk("r33_irq_new", irq_out, 8'h01);
    end

    // Randomized traffic with glitches, mask changes and occasional resets.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(9, 0) == 0) btn_in[i] = ~btn_in[i];
      if ($urandom_range(39, 0) == 0) irq_mask = 8'($urandom);
      if ($urandom_range(599, 0) == 0) do_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
